// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC rotator scheduler.
// The tag carries ownership of each rotator slot from issue to retire.
package cordic_pkg;

    localparam logic signed [15:0] PI          = 16'sd12868;
    localparam int                 STAGES      = 12;
    localparam int                 ROT_LATENCY = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
    } tag_t;

endpackage

// File: rtl/cordic_rot_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
// The pointer moves past the winner only when a grant is actually taken.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win_s;
    logic          found_s;
    int            cand_s;

    // wrapped search starting at the pointer; advance gates the grant itself
    always_comb begin
        gnt     = '0;
        win_s   = '0;
        found_s = 1'b0;
        cand_s  = 0;
        for (int k = 0; k < N; k++) begin
            cand_s = (int'(ptr_q) + k) % N;
            if (advance && !found_s && req[cand_s]) begin
                found_s     = 1'b1;
                gnt[cand_s] = 1'b1;
                win_s       = PW'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // next pointer: one past the winner, wrapping at N
    always_comb begin
        ptr_d = ptr_q;
        if (found_s) begin
            if (win_s == PW'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_s + PW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cordic_rot_sched.sv
// Shares one pipelined CORDIC rotator among NREQ requesters: arbitrates, issues,
// keeps the rotator fed with bubbles while work is in flight, and routes results home.
module cordic_rot_sched
    import cordic_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int LATENCY = ROT_LATENCY,
    parameter int MAX_OUT = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NREQ-1:0]                     req_valid,
    output logic [NREQ-1:0]                     req_ready,
    input  logic [NREQ*16-1:0]                  req_x,
    input  logic [NREQ*16-1:0]                  req_y,
    input  logic [NREQ*16-1:0]                  req_z,
    input  logic                                flush,
    output logic                                flush_done,
    output logic [15:0]                         cordic_x,
    output logic [15:0]                         cordic_y,
    output logic [15:0]                         cordic_z,
    output logic                                cordic_valid,
    input  logic [11:0]                         cordic_re,
    input  logic [11:0]                         cordic_im,
    output logic [NREQ-1:0]                     res_valid,
    output logic [11:0]                         res_re,
    output logic [11:0]                         res_im,
    output logic                                busy,
    output logic [$clog2(NREQ*MAX_OUT+1)-1:0]   inflight
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int IW = $clog2(NREQ * MAX_OUT + 1);

    sched_state_e    state_q, state_d;
    tag_t            tag_q [LATENCY];
    tag_t            tag_d [LATENCY];
    logic [CW-1:0]   cnt_q [NREQ];
    logic [CW-1:0]   cnt_d [NREQ];
    logic [IW-1:0]   inflight_q, inflight_d;
    logic [NREQ-1:0] res_valid_q, res_valid_d;
    logic [11:0]     res_re_q, res_re_d;
    logic [11:0]     res_im_q, res_im_d;
    logic            flush_done_q, flush_done_d;

    logic [NREQ-1:0] avail_s;
    logic [NREQ-1:0] gnt_s;
    logic            allow_s;
    logic            grant_s;
    logic [2:0]      gidx_s;
    logic            cv_s;
    tag_t            tail_s;
    logic            retire_s;

    // a requester may be granted only while under its outstanding limit
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            avail_s[i] = (cnt_q[i] < CW'(MAX_OUT));
        end
    end

    // flush blocks granting in the cycle it is seen, in any state
    assign allow_s = (state_q != DRAIN) && !flush;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid & avail_s),
        .advance (allow_s),
        .gnt     (gnt_s)
    );

    assign grant_s = |gnt_s;
    assign cv_s    = (state_q != IDLE) || grant_s;
    assign tail_s  = tag_q[LATENCY-1];
    // bubbles ride the pipeline too, so only a valid tail retires
    assign retire_s = tail_s.vld && cv_s;

    // decode the one-hot grant and steer that requester's operands; zero is a bubble
    always_comb begin
        gidx_s   = 3'd0;
        cordic_x = 16'd0;
        cordic_y = 16'd0;
        cordic_z = 16'd0;
        for (int i = 0; i < NREQ; i++) begin
            gidx_s   = gidx_s   | (3'(i) & {3{gnt_s[i]}});
            cordic_x = cordic_x | (req_x[16*i +: 16] & {16{gnt_s[i]}});
            cordic_y = cordic_y | (req_y[16*i +: 16] & {16{gnt_s[i]}});
            cordic_z = cordic_z | (req_z[16*i +: 16] & {16{gnt_s[i]}});
        end
    end

    // scheduler state transitions and drain-complete pulse
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    flush_done_d = 1'b1;
                end else if (grant_s) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = DRAIN;
                end else if (!grant_s && (inflight_q == IW'(0))) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (inflight_q == IW'(0)) begin
                    state_d      = IDLE;
                    flush_done_d = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // tag pipeline advances in lockstep with the rotator
    always_comb begin
        tag_d = tag_q;
        if (cv_s) begin
            tag_d[0] = '{vld: grant_s, idx: gidx_s};
            for (int k = 1; k < LATENCY; k++) begin
                tag_d[k] = tag_q[k-1];
            end
        end else begin
            tag_d = tag_q;
        end
    end

    // outstanding counters: grant and retire of the same owner cancel out
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (gnt_s[i] && !(retire_s && (tail_s.idx == 3'(i)))) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (!gnt_s[i] && retire_s && (tail_s.idx == 3'(i))) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
        case ({grant_s, retire_s})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01:   inflight_d = inflight_q - IW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // capture the retiring result for its owner
    always_comb begin
        res_valid_d = '0;
        res_re_d    = 12'd0;
        res_im_d    = 12'd0;
        if (retire_s) begin
            res_valid_d = NREQ'(1) << tail_s.idx;
            res_re_d    = cordic_re;
            res_im_d    = cordic_im;
        end else begin
            res_valid_d = '0;
        end
    end

    // state, pipeline, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            inflight_q   <= '0;
            res_valid_q  <= '0;
            res_re_q     <= 12'd0;
            res_im_q     <= 12'd0;
            flush_done_q <= 1'b0;
            for (int k = 0; k < LATENCY; k++) begin
                tag_q[k] <= '0;
            end
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            res_valid_q  <= res_valid_d;
            res_re_q     <= res_re_d;
            res_im_q     <= res_im_d;
            flush_done_q <= flush_done_d;
            tag_q        <= tag_d;
            cnt_q        <= cnt_d;
        end
    end

    assign req_ready    = gnt_s;
    assign cordic_valid = cv_s;
    assign res_valid    = res_valid_q;
    assign res_re       = res_re_q;
    assign res_im       = res_im_q;
    assign flush_done   = flush_done_q;
    assign busy         = (state_q != IDLE);
    assign inflight     = inflight_q;

endmodule

// File: tb/tb_cordic_rot_sched.sv
// Randomised scoreboard bench for cordic_rot_sched with a stand-in rotator whose
// stages advance only on valid cycles and which is never reset.
module tb_cordic_rot_sched;
    import cordic_pkg::*;

    localparam int N    = 4;
    localparam int LAT  = ROT_LATENCY;
    localparam int MAXO = 4;
    localparam int IW   = $clog2(N*MAXO+1);

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*16-1:0]  req_x, req_y, req_z;
    logic             flush;
    logic             flush_done;
    logic [15:0]      cordic_x, cordic_y, cordic_z;
    logic             cordic_valid;
    logic [11:0]      cordic_re, cordic_im;
    logic [N-1:0]     res_valid;
    logic [11:0]      res_re, res_im;
    logic             busy;
    logic [IW-1:0]    inflight;

    cordic_rot_sched #(.NREQ(N), .LATENCY(LAT), .MAX_OUT(MAXO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z), .flush(flush),
        .flush_done(flush_done), .cordic_x(cordic_x), .cordic_y(cordic_y),
        .cordic_z(cordic_z), .cordic_valid(cordic_valid), .cordic_re(cordic_re),
        .cordic_im(cordic_im), .res_valid(res_valid), .res_re(res_re),
        .res_im(res_im), .busy(busy), .inflight(inflight)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // stand-in rotator transfer function
    function automatic logic [23:0] rot_fn(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        logic [11:0] re;
        logic [11:0] im;
        re = x[15:4] ^ z[11:0];
        im = y[15:4] + z[15:4];
        return {re, im};
    endfunction

    logic [23:0] rot_pipe [LAT];
    always @(posedge clk) begin
        if (cordic_valid === 1'b1) begin
            for (int k = LAT-1; k > 0; k--) rot_pipe[k] <= rot_pipe[k-1];
            rot_pipe[0] <= rot_fn(cordic_x, cordic_y, cordic_z);
        end
    end
    assign cordic_re = rot_pipe[LAT-1][23:12];
    assign cordic_im = rot_pipe[LAT-1][11:0];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          due;
        logic [11:0] re;
        logic [11:0] im;
    } exp_t;

    exp_t sb [N][$];
    int   iss_t [$];
    int   iss_i [$];
    int   mstate = 0;   // 0 idle, 1 run, 2 drain
    int   mptr   = 0;
    logic exp_fd = 1'b0;

    // reference model: arbitration, counts and state from the issue history
    always @(negedge clk) begin
        int            tot;
        int            cnt [N];
        int            g;
        int            c;
        logic [N-1:0]  exp_rdy;
        logic [47:0]   exp_op;
        logic [23:0]   r;
        while (iss_t.size() > 0 && iss_t[0] < cyc - LAT) begin
            void'(iss_t.pop_front());
            void'(iss_i.pop_front());
        end
        tot = iss_t.size();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        foreach (iss_i[k]) cnt[iss_i[k]]++;
        if (rst !== 1'b0) begin
            for (int i = 0; i < N; i++) begin
                while (sb[i].size() > 0 && sb[i][$].due >= cyc) void'(sb[i].pop_back());
            end
            iss_t.delete();
            iss_i.delete();
            mstate = 0;
            mptr   = 0;
            exp_fd = 1'b0;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                c = (mptr + k) % N;
                if (g < 0 && req_valid[c] && cnt[c] < MAXO && mstate != 2 && !flush) g = c;
            end
            exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
            exp_op  = (g >= 0) ? {req_x[16*g +: 16], req_y[16*g +: 16], req_z[16*g +: 16]} : 48'd0;
            chk("req_ready", req_ready, exp_rdy);
            chk("cordic_valid", cordic_valid, (mstate != 0 || g >= 0));
            chk("operands", {cordic_x, cordic_y, cordic_z}, exp_op);
            chk("busy", busy, (mstate != 0));
            chk("inflight", inflight, tot);
            chk("flush_done", flush_done, exp_fd);
            exp_fd = 1'b0;
            case (mstate)
                0: if (flush) exp_fd = 1'b1; else if (g >= 0) mstate = 1;
                1: if (flush) mstate = 2; else if (g < 0 && tot == 0) mstate = 0;
                default: if (tot == 0) begin mstate = 0; exp_fd = 1'b1; end
            endcase
            if (g >= 0) begin
                iss_t.push_back(cyc);
                iss_i.push_back(g);
                mptr = (g + 1) % N;
                r = rot_fn(req_x[16*g +: 16], req_y[16*g +: 16], req_z[16*g +: 16]);
                sb[g].push_back('{due: cyc + LAT + 1, re: r[23:12], im: r[11:0]});
            end
        end
    end

    // monitor: every presented result must match its owner's oldest expectation
    always @(negedge clk) begin
        int   idx;
        exp_t e;
        #1;
        if (rst === 1'b0) begin
            if (res_valid !== '0) begin
                chk("res_onehot", $onehot(res_valid), 1);
                idx = 0;
                for (int i = N-1; i >= 0; i--) if (res_valid[i]) idx = i;
                if (sb[idx].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL res_unexpected: got res_valid %b expected none (cycle %0d)", res_valid, cyc);
                end else begin
                    e = sb[idx].pop_front();
                    chk("res_cycle", cyc, e.due);
                    chk("res_re", res_re, e.re);
                    chk("res_im", res_im, e.im);
                end
            end
            for (int i = 0; i < N; i++) begin
                while (sb[i].size() > 0 && sb[i][0].due <= cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL res_missing: requester %0d got nothing, expected result due cycle %0d", i, sb[i][0].due);
                    void'(sb[i].pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic f);
        req_valid = v;
        flush     = f;
        for (int i = 0; i < N; i++) begin
            req_x[16*i +: 16] = 16'($urandom);
            req_y[16*i +: 16] = 16'($urandom);
            req_z[16*i +: 16] = 16'($urandom);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((busy !== 1'b0 || inflight !== '0) && k < budget) begin
            step();
            k++;
        end
        n_checks++;
        if (busy !== 1'b0 || inflight !== '0) begin
            n_fail++;
            $display("FAIL wait_idle: busy %b inflight %0d after %0d cycles, expected 0/0", busy, inflight, budget);
        end
        step();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_re_im"}, {res_re, res_im}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_inflight"}, inflight, 0);
        chk({tag, "_flush_done"}, flush_done, 0);
        chk({tag, "_cordic"}, {cordic_valid, cordic_x, cordic_y, cordic_z}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0;
        int          lows;
        int          pulses;
        logic [23:0] r;
        rst = 1'b1;
        drive('0, 1'b0);
        repeat (3) step();
        rst = 1'b0;
        #1;
        check_all_zero("reset");
        step();

        // single request from requester 2
        req_valid = 4'b0100;
        req_x[32 +: 16] = 16'h1000;
        req_y[32 +: 16] = 16'h0000;
        req_z[32 +: 16] = 16'h0400;
        t0 = cyc;
        step();
        drive('0, 1'b0);
        lows = 0;
        while (res_valid === '0 && lows < 40) begin step(); lows++; end
        r = rot_fn(16'h1000, 16'h0000, 16'h0400);
        chk("single_latency", cyc - t0, LAT + 1);
        chk("single_res_valid", res_valid, 4'b0100);
        chk("single_res", {res_re, res_im}, r);
        wait_idle(40);

        // all requesters continuously valid
        for (int k = 0; k < 40; k++) begin drive(4'b1111, 1'b0); step(); end
        drive('0, 1'b0);
        wait_idle(40);

        // requester 0 alone hits its outstanding limit
        lows = 0;
        for (int k = 0; k < 19; k++) begin
            drive(4'b0001, 1'b0);
            #1;
            if (req_ready[0] === 1'b0) lows++;
            step();
        end
        chk("req0_ready_low_cycles", lows, 11);
        for (int k = 0; k < 20; k++) begin drive(4'b0001, 1'b0); step(); end
        drive('0, 1'b0);
        wait_idle(40);

        // gap traffic from requester 1
        drive(4'b0010, 1'b0);
        step();
        drive('0, 1'b0);
        repeat (19) step();
        drive(4'b0010, 1'b0);
        step();
        drive('0, 1'b0);
        wait_idle(40);

        // flush with three in flight and requesters still valid
        for (int k = 0; k < 3; k++) begin drive(4'b1111, 1'b0); step(); end
        drive(4'b1111, 1'b1);
        #1;
        chk("flush_ready", req_ready, 0);
        step();
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            drive(4'b1111, 1'b0);
            if (flush_done === 1'b1) pulses++;
            step();
        end
        chk("flush_done_pulses", pulses, 1);
        drive('0, 1'b0);
        wait_idle(40);

        // flush while idle
        drive('0, 1'b1);
        step();
        drive('0, 1'b0);
        chk("idle_flush_done", flush_done, 1);
        chk("idle_flush_busy", busy, 0);
        step();

        // reset with five in flight
        for (int k = 0; k < 5; k++) begin drive(4'b1111, 1'b0); step(); end
        rst = 1'b1;
        drive('0, 1'b0);
        step();
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (30) step();

        // randomised traffic with occasional flush
        for (int k = 0; k < 600; k++) begin
            drive(N'($urandom_range(0, 15)), ($urandom_range(0, 49) == 0));
            step();
        end
        drive('0, 1'b0);
        wait_idle(60);
        repeat (3) step();

        for (int i = 0; i < N; i++) chk("scoreboard_empty", sb[i].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_rot_sched.md
Name: cordic_rot_sched

Overview:
- Scheduler and arbiter sharing one 12-stage pipelined CORDIC rotator among NREQ requesters.
- Round-robin grant with valid/ready per requester; issues operands to the rotator and tracks ownership with a tag shift pipeline.
- Routes each 12-bit re/im result back to the owning requester.
- Keeps the rotator's rot_valid asserted with bubble issues while work is in flight, because its stages only advance on consecutive valid cycles; its sticky valid_o is ignored.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LATENCY, 14, cycles from an issue cycle to its result on cordic_re/cordic_im.
- MAX_OUT, 4, max outstanding transactions per requester.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; a transfer occurs when valid and ready are both high
- req_x  in  NREQ*16  signed x operands, requester i at [16i+15:16i]
- req_y  in  NREQ*16  signed y operands
- req_z  in  NREQ*16  signed angle, (16,12) radians
- flush  in  1  stop granting new work and drain everything in flight
- flush_done  out  1  one-cycle pulse when a drain completes
- cordic_x / cordic_y / cordic_z  out  16 each  operands to the rotator
- cordic_valid  out  1  drives the rotator's rot_valid
- cordic_re / cordic_im  in  12 each  rotator outputs
- res_valid  out  NREQ  one-hot result strobe; no backpressure
- res_re / res_im  out  12 each  result, valid while res_valid is nonzero
- busy  out  1  high when state is not IDLE
- inflight  out  $clog2(NREQ*MAX_OUT+1)  count of real transactions in flight

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, tag pipeline cleared, per-requester counters 0.
- Reset applies on the next edge, including mid-operation; in-flight results are discarded.
- Eligibility: requester i is eligible when req_valid[i]=1, its counter < MAX_OUT, and state is not DRAIN.
- Grant:
  - req_ready is combinational and one-hot: the eligible index at or after the pointer, searching with wrap.
  - After a grant the pointer moves to (granted+1) mod NREQ.
  - No grant leaves the pointer unchanged.
- Issue:
  - cordic_x/y/z are combinational: the granted operands, or 0/0/0 for a bubble.
  - cordic_valid=1 in RUN and DRAIN, 0 in IDLE.
- Tag pipeline:
  - LATENCY entries of {valid, idx}, shifted every cycle in which cordic_valid=1.
  - Entry 0 receives {grant?1:0, granted idx}.
  - While cordic_valid=0 the pipeline holds (it is empty in IDLE).
- Result delivery:
  - When the tail entry is valid and cordic_valid=1, register res_valid=onehot(idx), res_re=cordic_re, res_im=cordic_im.
  - Result is visible one cycle later; otherwise res_valid=0.
  - Bubble results are discarded.
- Counters: increment on grant, decrement on retire. Grant and retire in the same cycle for the same requester leave the counter unchanged. inflight follows the same rule.
- FSM:
  - IDLE -> RUN on any eligible request; the first grant occurs in the same cycle, so cordic_valid=1 that cycle.
  - RUN -> DRAIN when flush=1; no grant is made that cycle.
  - RUN -> IDLE when no eligible request, inflight=0, and no grant this cycle.
  - DRAIN -> IDLE when inflight=0; pulse flush_done on the transition.
  - flush in IDLE: flush_done pulses next cycle and the state stays IDLE.
- End-to-end latency: issue cycle t -> res_valid high in cycle t+LATENCY+1, given continuous cordic_valid, which the FSM guarantees.
- Back-to-back:
  - One issue per cycle sustained.
  - A single requester is limited to MAX_OUT outstanding, so its req_ready drops after 4 grants until the first retire.

Decomposition:
- Package cordic_pkg holds:
  - PI and STAGE constants;
  - the rotator latency constant, 14;
  - typedef sched_state_e {IDLE, RUN, DRAIN};
  - typedef tag_t {logic vld; logic [2:0] idx}.
- Sub-module rr_arbiter (parameter N): req, advance -> one-hot gnt, with the pointer inside.
- The CORDIC instance is external; the bench connects cordic_rot directly.

Test Plan:
- Single request: requester 2, x=0x1000, y=0, z=0x0400, issued at cycle 5.
  - Required: res_valid=4'b0100 at cycle 20.
  - Required: res_re/res_im match the rotator's direct output for the same operands.
  - Required: busy drops after inflight returns to 0.
- All four requesters holding valid continuously: grants follow 0,1,2,3,0,... with no gaps; each requester receives results in issue order.
- Requester 0 alone, valid held high: 4 grants, req_ready low for 11 cycles, regrant in the cycle its first result retires (counter 4 -> 3).
- Gap traffic: requester 1 issues at cycles 0 and 20. cordic_valid stays high through cycle 14; both results appear at exactly +15. Bubbles produce no res_valid.
- flush asserted with 3 in flight and requesters valid: req_ready=0 from that cycle, 3 results delivered, flush_done single pulse, state IDLE.
- rst asserted with 5 in flight: next cycle all outputs are 0; no stale res_valid afterwards even with the rotator pipeline unflushed.
